icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Read-only, direct-mapped instruction cache. It answers the IF stage's fetch requests (mem_read/mem_address to mem_rdata/mem_resp) and is the responder end of the fetch interface.
- On a miss it refills one 256-bit line from physical memory as a 4-beat, 64-bit burst, then returns the requested word.
- Sits between IF and the instruction-side memory arbiter.

Parameters:
SETS, 16, number of lines; power of 2, minimum 2; index width IDX = log2(SETS)
OFFSET_BITS, 5, byte offset within a 32-byte line (fixed at 5)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
mem_read  input  1  IF fetch request; held high with mem_address stable until mem_resp
mem_address  input  32  fetch byte address; bits [1:0] ignored
mem_rdata  output  32  instruction word; valid only while mem_resp=1
mem_resp  output  1  one-cycle completion pulse to IF
pmem_read  output  1  burst read request to physical memory
pmem_address  output  32  line-aligned burst address (bits [4:0]=0)
pmem_rdata  input  64  burst beat data
pmem_resp  input  1  beat valid; exactly 4 beats per burst, in ascending order

Behaviour:
- Address split: tag = addr[31:5+IDX], index = addr[4+IDX:5], word = addr[4:2].
- Arrays: valid[SETS], tag[SETS], data[SETS] of 256 bits each.
- Reset: all valid bits cleared, FSM goes to IDLE, and mem_resp, pmem_read, pmem_address and mem_rdata are all 0.
  - Tag and data arrays are not cleared.
  - Reset takes priority over every other event, including mid-burst. pmem_read drops the cycle after reset is sampled, and the partial line is discarded.
  - The memory side is reset together with this block.
- States are IDLE, CHECK, FILL and DONE.
- IDLE:
  - If mem_read=1, latch mem_address into the request register and go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (hit):
  - A hit is valid[index] && tag match.
  - On a hit, assert mem_resp=1 with mem_rdata = data[index] word [word] in this same cycle, then go to IDLE.
  - Hit latency is 2 cycles from first sampling mem_read; throughput is 1 hit per 2 cycles.
- CHECK (miss): go to FILL, with pmem_read=1 and pmem_address = {req[31:5],5'b0} registered for the next cycle.
- FILL:
  - Hold pmem_read and pmem_address stable.
  - A beat counter (0..3) advances only on pmem_resp=1. Beat k is written to line bits [64k+63:64k] of a fill buffer.
  - Any number of idle cycles between beats is tolerated.
  - On the 4th beat, deassert pmem_read the next cycle and write the buffer, tag and valid=1 into the indexed set; this overwrites any prior line (no writeback, since the cache is read-only). Then go to DONE.
- DONE:
  - Assert mem_resp=1 with the requested word taken from the freshly written line, then go to IDLE.
  - Miss latency is 4 beats plus 3 cycles of overhead.
- mem_read dropped during FILL:
  - The fill still completes and the line is installed. DONE still lasts one cycle, but mem_resp is suppressed.
  - A new request is accepted only in IDLE.
- Address changes while busy are ignored; the latched request address is used.
- mem_resp is never asserted outside CHECK-hit or DONE, and never for 2 consecutive cycles.
- pmem_read is high only in FILL.

Test Plan:
- Reset: hold rst 2 cycles -> mem_resp=0, pmem_read=0, pmem_address=0; then a fetch to 0x0 misses and a burst at 0x0 is issued.
- Cold miss at 0x00000064 -> pmem_read=1 with pmem_address=0x00000060. Return beats 0x11111111_00000000, 0x33333333_22222222, 0x55555555_44444444, 0x77777777_66666666 -> mem_resp one cycle with mem_rdata=0x11111111 (word 1), exactly once.
- Hit after fill: fetch 0x00000078 -> mem_resp in the 2nd cycle after request, mem_rdata=0x66666666, pmem_read stays 0.
- Conflict (SETS=16): fetch 0x00000260 (index 3, different tag) -> new burst at 0x00000260. Refetching 0x00000064 then misses again.
- Beat stalls: insert 3 idle cycles between each pmem_resp -> pmem_read/pmem_address stable throughout, correct word returned, exactly 4 beats consumed.
- rst asserted after beat 2 of a fill -> pmem_read=0 next cycle, no mem_resp. A subsequent fetch to the same line misses, proving the line was not installed.

Source files
------------

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache; refills a 256-bit line as a 4x64-bit burst on a miss.
// Latency: hit answers 2 cycles after mem_read is first sampled; a miss takes 4 beats + 3 cycles.
// Backpressure: IF holds mem_read until mem_resp; memory beats may stall arbitrarily via pmem_resp.
module icache_responder #(
   parameter int SETS        = 16,
   parameter int OFFSET_BITS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic [31:0] mem_address,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        pmem_read,
   output logic [31:0] pmem_address,
   input  logic [63:0] pmem_rdata,
   input  logic        pmem_resp
);

   localparam int IDX  = $clog2(SETS);
   localparam int TAGW = 32 - OFFSET_BITS - IDX;

   typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} state_t;

   state_t state_q, state_d;

   // Latched request; byte-offset bits [1:0] carry no information for word fetches.
   logic [31:2]     req_q;
   logic [SETS-1:0] valid_q;
   logic [TAGW-1:0] tag_q  [SETS];
   logic [255:0]    data_q [SETS];
   logic [191:0]    fill_q;
   logic [1:0]      beat_q;
   logic            pmem_read_q;
   logic [31:0]     pmem_addr_q;
   logic            dropped_q;

   logic [IDX-1:0]  req_idx;
   logic [TAGW-1:0] req_tag;
   logic [2:0]      req_word;
   logic            hit;
   logic [31:0]     sel_word;

   assign req_idx  = req_q[OFFSET_BITS+IDX-1:OFFSET_BITS];
   assign req_tag  = req_q[31:OFFSET_BITS+IDX];
   assign req_word = req_q[4:2];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign sel_word = data_q[req_idx][{req_word, 5'd0} +: 32];

   assign pmem_read    = pmem_read_q;
   assign pmem_address = pmem_addr_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and response outputs; responses only from a CHECK hit or from DONE.
   always_comb begin
      state_d   = state_q;
      mem_resp  = 1'b0;
      mem_rdata = 32'd0;
      case (state_q)
         IDLE: begin
            if (mem_read) state_d = CHECK;
         end
         CHECK: begin
            if (hit) begin
               mem_resp  = 1'b1;
               mem_rdata = sel_word;
               state_d   = IDLE;
            end else begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (pmem_resp && beat_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            // A requester that walked away mid-fill gets no pulse; the line is still installed.
            if (mem_read && !dropped_q) begin
               mem_resp  = 1'b1;
               mem_rdata = sel_word;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, valid bits and burst control; reset abandons any burst in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q       <= '0;
         valid_q     <= '0;
         beat_q      <= 2'd0;
         pmem_read_q <= 1'b0;
         pmem_addr_q <= 32'd0;
         dropped_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_read) req_q <= mem_address[31:2];
            end
            CHECK: begin
               if (!hit) begin
                  pmem_read_q <= 1'b1;
                  pmem_addr_q <= {req_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  beat_q      <= 2'd0;
                  dropped_q   <= 1'b0;
               end
            end
            FILL: begin
               if (!mem_read) dropped_q <= 1'b1;
               if (pmem_resp) begin
                  beat_q <= beat_q + 2'd1;
                  if (beat_q == 2'd3) begin
                     pmem_read_q      <= 1'b0;
                     valid_q[req_idx] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Fill buffer and line install; tag/data contents are meaningless until valid is set.
   always_ff @(posedge clk) begin
      if (!rst && state_q == FILL && pmem_resp) begin
         case (beat_q)
            2'd0: fill_q[63:0]    <= pmem_rdata;
            2'd1: fill_q[127:64]  <= pmem_rdata;
            2'd2: fill_q[191:128] <= pmem_rdata;
            default: begin
               data_q[req_idx] <= {pmem_rdata, fill_q};
               tag_q[req_idx]  <= req_tag;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a burst memory model and a response scoreboard.
// Latency: n/a (bench).
// Backpressure: memory model inserts a configurable number of idle cycles before each beat.
module tb_icache_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic [31:0] mem_address;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        pmem_read;
   logic [31:0] pmem_address;
   logic [63:0] pmem_rdata = 64'd0;
   logic        pmem_resp  = 1'b0;

   int          total = 0;
   int          bad   = 0;
   int          gap   = 0;
   int          gcnt  = 0;
   int          beats_sent  = 0;
   int          total_beats = 0;
   int          resp_total  = 0;
   logic        last_resp   = 1'b0;
   logic [31:0] exp_line    = 32'd0;
   logic [31:0] exp_q [$];

   icache_responder #(.SETS(16), .OFFSET_BITS(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   // Backing memory contents: line 0x60 holds the n*0x11111111 pattern, elsewhere address-derived.
   function automatic logic [31:0] exp_word(input logic [31:0] a);
      if (a[31:5] == 27'h3) return {29'd0, a[4:2]} * 32'h11111111;
      return {a[31:2], 2'b00} ^ 32'hC0DE0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory model: four ascending beats per burst, each preceded by 'gap' idle cycles.
   always @(negedge clk) begin
      if (rst) begin
         beats_sent = 0;
         gcnt       = 0;
         pmem_resp  = 1'b0;
      end else if (pmem_read && beats_sent < 4) begin
         if (gcnt < gap) begin
            gcnt++;
            pmem_resp = 1'b0;
         end else begin
            gcnt = 0;
            chk("beat_addr", pmem_address, exp_line);
            pmem_rdata = {exp_word(exp_line + 32'(8*beats_sent + 4)),
                          exp_word(exp_line + 32'(8*beats_sent))};
            pmem_resp  = 1'b1;
            beats_sent++;
            total_beats++;
         end
      end else begin
         pmem_resp = 1'b0;
         if (!pmem_read) begin
            beats_sent = 0;
            gcnt       = 0;
         end
      end
   end

   // Response monitor: count pulses and flag back-to-back responses.
   always @(negedge clk) begin
      if (mem_resp) begin
         resp_total++;
         chk("resp_back_to_back", last_resp, 1'b0);
      end
      last_resp = mem_resp;
   end

   // One fetch: push expected word, wait (bounded) for mem_resp, compare, then check side effects.
   task automatic fetch(input logic [31:0] a, input int exp_lat, input int exp_beats);
      int   cyc  = 0;
      int   b0;
      int   r0;
      logic seen = 1'b0;
      logic [31:0] exp_w;
      @(posedge clk); #1;
      b0          = total_beats;
      r0          = resp_total;
      exp_line    = {a[31:5], 5'b0};
      exp_q.push_back(exp_word(a));
      mem_read    = 1'b1;
      mem_address = a;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (mem_resp) seen = 1'b1;
      end
      chk("resp_seen", seen, 1'b1);
      exp_w = exp_q.pop_front();
      if (seen) begin
         chk("latency", cyc, exp_lat);
         chk("rdata", mem_rdata, exp_w);
      end
      @(posedge clk); #1;
      mem_read    = 1'b0;
      mem_address = $urandom;
      repeat (3) @(posedge clk);
      #1;
      chk("resp_once", resp_total - r0, 1);
      chk("beats", total_beats - b0, exp_beats);
      chk("pmem_idle", pmem_read, 1'b0);
   endtask

   initial begin
      int r0;
      int b0;
      int cyc;

      rst         = 1'b1;
      mem_read    = 1'b0;
      mem_address = 32'd0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_resp", mem_resp, 1'b0);
      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_address", pmem_address, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      rst = 1'b0;

      // First fetch after reset misses and bursts from 0x0.
      fetch(32'h0000_0000, 7, 4);

      // Cold miss in set 3, then a hit on another word of the same line.
      fetch(32'h0000_0064, 7, 4);
      fetch(32'h0000_0078, 2, 0);

      // Conflict in set 3 evicts line 0x60; set 0 is untouched.
      fetch(32'h0000_0260, 7, 4);
      fetch(32'h0000_0064, 7, 4);
      fetch(32'h0000_001C, 2, 0);

      // Three idle cycles before every beat.
      gap = 3;
      fetch(32'h0000_014C, 19, 4);
      gap = 0;

      // Requester drops mem_read mid-fill: no response, but the line is installed.
      @(posedge clk); #1;
      r0          = resp_total;
      b0          = total_beats;
      exp_line    = 32'h0000_00A0;
      mem_read    = 1'b1;
      mem_address = 32'h0000_00A4;
      cyc = 0;
      while (!pmem_read && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("drop_fill_start", pmem_read, 1'b1);
      mem_read = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("drop_no_resp", resp_total - r0, 0);
      chk("drop_beats", total_beats - b0, 4);
      fetch(32'h0000_00A4, 2, 0);

      // Reset after two beats of a fill: burst abandoned, line not installed.
      @(posedge clk); #1;
      r0          = resp_total;
      exp_line    = 32'h0000_0400;
      mem_read    = 1'b1;
      mem_address = 32'h0000_0404;
      cyc = 0;
      while (beats_sent < 2 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("rst_mid_two_beats", beats_sent, 2);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_pmem_read", pmem_read, 1'b0);
      chk("rst_mid_mem_resp", mem_resp, 1'b0);
      @(posedge clk); #1;
      rst      = 1'b0;
      mem_read = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mid_no_resp", resp_total - r0, 0);
      fetch(32'h0000_0404, 7, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
